// File: rtl/pdp8_uart_pkg.sv
// Shared definitions for the pdp8_uart serial line interface:
// frame geometry and the TX/RX state encodings.
package pdp8_uart_pkg;

    // 1 start + 8 data + 1 stop
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/pdp8_uart_rx.sv
// Receive half of pdp8_uart: 2-flop synchroniser on rxd, 8N1 framing FSM
// sampling mid-bit, and the single-byte holding register with its flags.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   rxd_i          asynchronous serial input
//   rx_ack_i       consumer has taken the byte; clears valid and flags
//   rx_data_o      last good character
//   rx_valid_o     unacknowledged character present
//   rx_ferr_o      sticky framing error
//   rx_overrun_o   sticky overrun
module pdp8_uart_rx
    import pdp8_uart_pkg::*;
#(
    parameter int unsigned BIT_CLKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    input  logic       rx_ack_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_ferr_o,
    output logic       rx_overrun_o
);

    localparam int unsigned CNT_W = $clog2(BIT_CLKS);
    localparam int unsigned HALF  = BIT_CLKS / 2;

    logic [1:0]       sync_q;
    logic             rxs_prev_q;
    logic             rxs;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             good_q, good_d;
    logic             bad_q, bad_d;
    logic             half_hit, full_hit;

    logic [7:0]       data_q;
    logic             valid_q, ferr_q, overrun_q;

    assign rxs      = sync_q[1];
    assign half_hit = (cnt_q == CNT_W'(HALF - 1));
    assign full_hit = (cnt_q == CNT_W'(BIT_CLKS - 1));

    // Synchroniser plus one-cycle history for start-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rxd_i};
            rxs_prev_q <= rxs;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (!rxs && rxs_prev_q) state_d = RX_START;
            RX_START: if (half_hit) state_d = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && (bit_q == 4'(DATA_BITS - 1))) state_d = RX_STOP;
            RX_STOP:  if (full_hit) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Counters, shifter and completion pulses
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            // Edge is detected one cycle after the synchroniser shows 0,
            // so the half-bit count starts at 1.
            RX_IDLE: begin
                cnt_d = CNT_W'(1);
                bit_d = '0;
            end
            RX_START: if (half_hit) cnt_d = '0;
            RX_DATA: if (full_hit) begin
                cnt_d   = '0;
                bit_d   = bit_q + 4'd1;
                shift_d = {rxs, shift_q[7:1]};
            end
            RX_STOP: if (full_hit) begin
                good_d = rxs;
                bad_d  = ~rxs;
            end
            default: cnt_d = '0;
        endcase
    end

    // Holding register and sticky flags, updated the edge after the stop sample
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (good_q) begin
            data_q    <= shift_q;
            valid_q   <= 1'b1;
            ferr_q    <= ferr_q & ~rx_ack_i;
            overrun_q <= rx_ack_i ? 1'b0 : (overrun_q | valid_q);
        end else begin
            if (rx_ack_i) begin
                valid_q   <= 1'b0;
                ferr_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (bad_q) ferr_q <= 1'b1;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign rx_ferr_o    = ferr_q;
    assign rx_overrun_o = overrun_q;

endmodule

// File: rtl/pdp8_uart.sv
// Serial line interface below the pdp8_tt teletype controller. Transmits
// one character at a time as 8N1 on txd and hands received characters to
// the keyboard side through pdp8_uart_rx.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   tx_data/tx_req  character and request, accepted while tx_busy==0
//   tx_busy         transmitter shifting a character
//   tx_done         one-cycle pulse after the stop bit
//   txd             serial output, idle high
//   rxd             serial input
//   rx_data/rx_valid/rx_ack/rx_ferr/rx_overrun  receive holding register
module pdp8_uart
    import pdp8_uart_pkg::*;
#(
    parameter int unsigned BIT_CLKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_ferr,
    output logic       rx_overrun
);

    localparam int unsigned CNT_W = $clog2(BIT_CLKS);

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_last;
    logic             tx_accept;

    assign tx_last   = (tx_cnt_q == CNT_W'(BIT_CLKS - 1));
    assign tx_accept = (tx_state_q == TX_IDLE) && tx_req && !tx_busy_q;

    // TX state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // TX next state; tx_bit_q holds the frame bit index (start = 0)
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (tx_accept) tx_state_d = TX_START;
            TX_START: if (tx_last) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_last && (tx_bit_q == 4'(FRAME_BITS - 2))) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_last) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs follow the state one cycle later, so txd/tx_busy change
    // the edge after the request is accepted.
    always_comb begin
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = 1'b1;
        tx_busy_d  = (tx_state_q != TX_IDLE);
        // busy still high while already idle marks the cycle after the stop bit
        tx_done_d  = tx_busy_q && (tx_state_q == TX_IDLE);
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (tx_accept) tx_shift_d = tx_data;
            end
            TX_START: begin
                txd_d = 1'b0;
                if (tx_last) begin
                    tx_cnt_d = '0;
                    tx_bit_d = 4'd1;
                end
            end
            TX_DATA: begin
                txd_d = tx_shift_q[0];
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_shift_d = {1'b1, tx_shift_q[7:1]};
                end
            end
            TX_STOP: txd_d = 1'b1;
            default: tx_cnt_d = '0;
        endcase
    end

    assign txd     = txd_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

    pdp8_uart_rx #(
        .BIT_CLKS(BIT_CLKS)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rxd_i       (rxd),
        .rx_ack_i    (rx_ack),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ferr_o   (rx_ferr),
        .rx_overrun_o(rx_overrun)
    );

endmodule

// File: tb/tb_pdp8_uart.sv
// Self-checking bench for pdp8_uart with BIT_CLKS=16. Expected TX bits and
// RX bytes are queued when stimulus is driven and popped when the DUT
// produces them. Outputs are sampled on the falling edge.
module tb_pdp8_uart;
    import pdp8_uart_pkg::*;

    localparam int unsigned BC = 16;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_busy;
    logic       tx_done;
    logic       txd;
    logic       rxd;
    logic       rxd_drv;
    logic       loopback;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_ferr;
    logic       rx_overrun;

    int unsigned n_pass;
    int unsigned n_total;
    logic [7:0]  exp_q[$];
    logic        txq[$];

    assign rxd = loopback ? txd : rxd_drv;

    pdp8_uart #(.BIT_CLKS(BC)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .txd       (txd),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .rx_ferr   (rx_ferr),
        .rx_overrun(rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive one frame on rxd starting at the next falling edge (negedge k=0).
    // ack_at pulses rx_ack during the cycle that starts at negedge ack_at.
    // rise_k reports the negedge at which rx_valid was first seen rising.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int ack_at, output int rise_k);
        logic pv;
        pv     = rx_valid;
        rise_k = -1;
        for (int k = 0; k < 10 * BC; k++) begin
            @(negedge clk);
            if (rise_k < 0 && rx_valid && !pv) rise_k = k;
            pv = rx_valid;
            if (k < BC)              rxd_drv = 1'b0;
            else if (k >= 9 * BC)    rxd_drv = stop_bit;
            else                     rxd_drv = b[(k / BC) - 1];
            rx_ack = (k == ack_at);
        end
        @(negedge clk);
        if (rise_k < 0 && rx_valid && !pv) rise_k = 10 * BC;
        rxd_drv = 1'b1;
        rx_ack  = 1'b0;
    endtask

    task automatic push_tx_bits(input logic [7:0] b);
        txq.push_back(1'b0);
        for (int i = 0; i < 8; i++) txq.push_back(b[i]);
        txq.push_back(1'b1);
    endtask

    task automatic pulse_ack();
        @(negedge clk); rx_ack = 1'b1;
        @(negedge clk); rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (txd !== 1'b1) $display("FAIL reset_txd got=%b exp=1", txd); else n_pass++;
        n_total++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", tx_busy); else n_pass++;
        n_total++; if (tx_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", tx_done); else n_pass++;
        n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data); else n_pass++;
        n_total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); else n_pass++;
        n_total++; if (rx_ferr !== 1'b0) $display("FAIL reset_rx_ferr got=%b exp=0", rx_ferr); else n_pass++;
        n_total++; if (rx_overrun !== 1'b0) $display("FAIL reset_rx_overrun got=%b exp=0", rx_overrun); else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // negedge m follows accept edge N by m-1 edges; bit k is checked mid-bit at m=9+16k
    task automatic test_tx();
        logic eb;
        push_tx_bits(8'h55);
        tx_data = 8'h55; tx_req = 1'b1;
        for (int m = 1; m <= 163; m++) begin
            @(negedge clk);
            if (m == 1) begin
                tx_req = 1'b0; tx_data = 8'h00;
                n_total++; if (tx_busy !== 1'b0) $display("FAIL tx_busy_m1 got=%b exp=0", tx_busy); else n_pass++;
            end
            if (m == 2) begin
                n_total++; if (tx_busy !== 1'b1) $display("FAIL tx_busy_m2 got=%b exp=1", tx_busy); else n_pass++;
            end
            if (m >= 9 && m <= 153 && ((m - 9) % BC) == 0) begin
                eb = txq.pop_front();
                n_total++; if (txd !== eb) $display("FAIL tx55_bit%0d got=%b exp=%b", (m - 9) / BC, txd, eb); else n_pass++;
            end
            if (m == 161) begin
                n_total++; if (tx_done !== 1'b0) $display("FAIL tx_done_early got=%b exp=0", tx_done); else n_pass++;
            end
            if (m == 162) begin
                n_total++; if (tx_done !== 1'b1) $display("FAIL tx_done_161 got=%b exp=1", tx_done); else n_pass++;
                n_total++; if (tx_busy !== 1'b0) $display("FAIL tx_busy_at_done got=%b exp=0", tx_busy); else n_pass++;
            end
            if (m == 163) begin
                n_total++; if (tx_done !== 1'b0) $display("FAIL tx_done_width got=%b exp=0", tx_done); else n_pass++;
            end
        end
    endtask

    // A new request raised in the tx_done cycle is accepted straight away
    task automatic test_back_to_back();
        logic eb;
        tx_data = 8'hC3; tx_req = 1'b1;
        for (int m = 1; m <= 162; m++) begin
            @(negedge clk);
            if (m == 1) begin tx_req = 1'b0; tx_data = 8'h00; end
            if (m == 162) begin
                n_total++; if (tx_done !== 1'b1) $display("FAIL b2b_first_done got=%b exp=1", tx_done); else n_pass++;
                push_tx_bits(8'h96);
                tx_data = 8'h96; tx_req = 1'b1;
            end
        end
        for (int m = 1; m <= 163; m++) begin
            @(negedge clk);
            if (m == 1) begin tx_req = 1'b0; tx_data = 8'h00; end
            if (m == 2) begin
                n_total++; if (tx_busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", tx_busy); else n_pass++;
            end
            if (m >= 9 && m <= 153 && ((m - 9) % BC) == 0) begin
                eb = txq.pop_front();
                n_total++; if (txd !== eb) $display("FAIL tx96_bit%0d got=%b exp=%b", (m - 9) / BC, txd, eb); else n_pass++;
            end
            if (m == 162) begin
                n_total++; if (tx_done !== 1'b1) $display("FAIL b2b_second_done got=%b exp=1", tx_done); else n_pass++;
            end
        end
    endtask

    task automatic test_rx_basic();
        int rk;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, -1, rk);
        n_total++; if (rk != 155) $display("FAIL rx_valid_timing got=%0d exp=155", rk); else n_pass++;
        n_total++; if (rx_data !== exp_q[0]) $display("FAIL rx_a3_data got=%h exp=%h", rx_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        n_total++; if (rx_ferr !== 1'b0) $display("FAIL rx_a3_ferr got=%b exp=0", rx_ferr); else n_pass++;
        pulse_ack();
        @(negedge clk);
        n_total++; if (rx_valid !== 1'b0) $display("FAIL rx_ack_clear got=%b exp=0", rx_valid); else n_pass++;
    endtask

    task automatic test_glitch();
        int rk;
        @(negedge clk); rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        n_total++; if (rx_valid !== 1'b0) $display("FAIL glitch_valid got=%b exp=0", rx_valid); else n_pass++;
        n_total++; if (dut.u_rx.state_q !== RX_IDLE) $display("FAIL glitch_idle got=%0d exp=%0d", dut.u_rx.state_q, RX_IDLE); else n_pass++;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1, rk);
        n_total++; if (rx_valid !== 1'b1) $display("FAIL rx_3c_valid got=%b exp=1", rx_valid); else n_pass++;
        n_total++; if (rx_data !== exp_q[0]) $display("FAIL rx_3c_data got=%h exp=%h", rx_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
    endtask

    // Leaves 8'h3C unacknowledged before the bad frame
    task automatic test_ferr();
        int rk;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b0, -1, rk);
        repeat (3) @(negedge clk);
        n_total++; if (rx_ferr !== 1'b1) $display("FAIL ferr_set got=%b exp=1", rx_ferr); else n_pass++;
        n_total++; if (rx_valid !== 1'b1) $display("FAIL ferr_valid_kept got=%b exp=1", rx_valid); else n_pass++;
        n_total++; if (rx_data !== 8'h3C) $display("FAIL ferr_data_kept got=%h exp=3c", rx_data); else n_pass++;
        pulse_ack();
        @(negedge clk);
        n_total++; if (rx_ferr !== 1'b0) $display("FAIL ferr_ack_clear got=%b exp=0", rx_ferr); else n_pass++;
        n_total++; if (rx_valid !== 1'b0) $display("FAIL ferr_ack_valid got=%b exp=0", rx_valid); else n_pass++;
    endtask

    task automatic test_overrun();
        int rk;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, rk);
        n_total++; if (rx_data !== exp_q[0]) $display("FAIL ovr_first_data got=%h exp=%h", rx_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, -1, rk);
        n_total++; if (rx_data !== exp_q[0]) $display("FAIL ovr_second_data got=%h exp=%h", rx_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        n_total++; if (rx_overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", rx_overrun); else n_pass++;
        n_total++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid got=%b exp=1", rx_valid); else n_pass++;
        pulse_ack();
        @(negedge clk);
        n_total++; if (rx_overrun !== 1'b0) $display("FAIL ovr_ack_clear got=%b exp=0", rx_overrun); else n_pass++;
        // Second pass: ack lands in the completion cycle of the second frame
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, rk);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 154, rk);
        n_total++; if (rx_data !== exp_q[0]) $display("FAIL ack_coinc_data got=%h exp=%h", rx_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        n_total++; if (rx_overrun !== 1'b0) $display("FAIL ack_coinc_overrun got=%b exp=0", rx_overrun); else n_pass++;
        n_total++; if (rx_valid !== 1'b1) $display("FAIL ack_coinc_valid got=%b exp=1", rx_valid); else n_pass++;
        pulse_ack();
    endtask

    // Reset during data bit 3 (frame bit 4) of 8'hF0, whose bit 3 is 0
    task automatic test_reset_mid_tx();
        tx_data = 8'hF0; tx_req = 1'b1;
        for (int m = 1; m <= 4 * BC + 9; m++) begin
            @(negedge clk);
            if (m == 1) begin tx_req = 1'b0; tx_data = 8'h00; end
        end
        n_total++; if (txd !== 1'b0) $display("FAIL midtx_bit3 got=%b exp=0", txd); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (txd !== 1'b1) $display("FAIL midtx_reset_txd got=%b exp=1", txd); else n_pass++;
        n_total++; if (tx_busy !== 1'b0) $display("FAIL midtx_reset_busy got=%b exp=0", tx_busy); else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        bit seen;
        loopback = 1'b1;
        exp_q.push_back(8'hFF);
        @(negedge clk);
        tx_data = 8'hFF; tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (rx_valid) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL loopback_timeout got=no_rx_valid exp=rx_valid within 400 cycles");
        else n_pass++;
        n_total++; if (rx_data !== exp_q[0]) $display("FAIL loopback_data got=%h exp=%h", rx_data, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        n_total++; if (rx_ferr !== 1'b0) $display("FAIL loopback_ferr got=%b exp=0", rx_ferr); else n_pass++;
        loopback = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        reset    = 1'b0;
        tx_req   = 1'b0;
        tx_data  = 8'h00;
        rxd_drv  = 1'b1;
        rx_ack   = 1'b0;
        loopback = 1'b0;

        test_reset();
        test_tx();
        test_back_to_back();
        test_rx_basic();
        test_glitch();
        test_ferr();
        test_overrun();
        test_reset_mid_tx();
        test_loopback();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
